id_stage_pipe: RTL
==================

// Module: id_stage_pipe
// PURPOSE
//  Parametrised RISC-V decode stage with registered ID/EX output. Decodes the instruction,
//  generates control and immediates, and reads a resettable register file with optional WB->ID bypass.
//  Detects load-use hazards against the EX stage, stalls IF/ID, and inserts bubbles; also honours branch flush.
//  Sits between the IF/ID register and EX; all outputs feed EX directly.
// PARAMETERS
//  XLEN       32  datapath/register width
//  NREG       32  register count; index width RW = $clog2(NREG); reg 0 reads as 0
//  BYPASS_WB  1   1: same-cycle WB write visible on ID read; 0: old value read
//  HAZARD_EN  1   1: load-use detection active; 0: hazard_stall tied 0
//  CNT_W      16  width of the saturating stall-cycle counter
// PORTS
//  clk              in   1      rising-edge clock
//  reset            in   1      synchronous, active-high
//  valid_id         in   1      IF/ID holds a real instruction
//  pc_id            in   XLEN   PC of instruction in ID
//  instr_id         in   32     instruction word in ID
//  regwrite_wb      in   1      WB write enable
//  rd_wb            in   RW     WB destination
//  data_wb          in   XLEN   WB write data
//  memread_ex       in   1      instruction now in EX is a load
//  rd_ex            in   RW     destination of instruction in EX
//  flush            in   1      branch taken: discard instruction in ID
//  hazard_stall     out  1      combinational: hold PC and IF/ID this cycle
//  valid_ex         out  1      ID/EX register holds a real instruction
//  pc_ex, imm_ex    out  XLEN   registered PC, sign-extended immediate
//  rs1_data_ex, rs2_data_ex out XLEN  registered operands
//  rs1_ex, rs2_ex, rd_ex_o out RW  registered register indices
//  funct3_ex/funct7_ex out 3/7  registered function fields
//  regwrite_ex, memtoreg_ex, memread_ex_o, memwrite_ex, alusrc_ex, branch_ex out 1  control
//  aluop_ex         out  2      00 ld/st add, 01 branch sub, 10 R/I funct decode
//  illegal_ex       out  1      registered: valid unknown opcode
//  stall_cnt        out  CNT_W  cycles hazard_stall was 1, saturating at all-ones
// BEHAVIOUR
//  - Reset: every ID/EX output, stall_cnt and all NREG registers cleared to 0. Reset wins over all inputs.
//  - Regfile write at posedge when regwrite_wb && rd_wb!=0; writes to reg 0 ignored.
//  - Read: rsN==0 -> 0; else if BYPASS_WB && regwrite_wb && rd_wb==rsN -> data_wb; else stored value.
//  - Decode (opcode): 0110011 R; 0010011 I-ALU; 0000011 load; 0100011 store; 1100011 branch.
//    R: regwrite, aluop 10. I-ALU: regwrite, alusrc, aluop 10. load: regwrite, memtoreg, memread, alusrc, aluop 00.
//    store: memwrite, alusrc, aluop 00. branch: branch, aluop 01. Other: all control 0, illegal=1.
//  - Imm: I {instr[31:20]}, S {instr[31:25],instr[11:7]}, B {instr[31],instr[7],instr[30:25],instr[11:8],0},
//    sign-extended to XLEN; R/unknown -> 0.
//  - uses_rs1 for all five legal types; uses_rs2 for R, store, branch.
//  - hazard = HAZARD_EN && valid_id && memread_ex && rd_ex!=0 &&
//    ((uses_rs1 && rd_ex==rs1) || (uses_rs2 && rd_ex==rs2)).
//  - hazard_stall = hazard && !flush (flush has priority; flushed instruction cannot stall).
//  - Next ID/EX load (1-cycle latency): if flush || hazard || !valid_id -> bubble: valid_ex=0, all control 0,
//    illegal_ex=0, datapath fields don't-care (implementation drives 0). Else capture decoded bundle, valid_ex=1.
//  - Stalled instruction is re-presented next cycle by IF/ID; load then in MEM so hazard clears: exactly one bubble.
//  - stall_cnt increments on each cycle hazard_stall=1; holds at 2^CNT_W-1.
//  - No internal FSM beyond ID/EX register, regfile and counter; behaviour purely cycle-by-cycle.
// TESTING
//  1 reset=1 two cycles after regfile writes -> all regs read 0, valid_ex=0, stall_cnt=0.
//  2 WB writes x5=0xDEADBEEF while ID decodes add x1,x5,x6 (BYPASS_WB=1) -> rs1_data_ex=0xDEADBEEF next cycle; BYPASS_WB=0 -> old value.
//  3 memread_ex=1,rd_ex=3, ID add x4,x3,x2 -> hazard_stall=1, next valid_ex=0, stall_cnt=1; repeat with rd_ex=0 -> no stall.
//  4 same hazard plus flush=1 -> hazard_stall=0, bubble inserted, stall_cnt unchanged.
//  5 sw x7,-4(x2) -> imm_ex=0xFFFFFFFC, memwrite_ex=1, aluop_ex=00, regwrite_ex=0; beq offset -8 -> imm_ex=0xFFFFFFF8, aluop 01.
//  6 opcode 1111111 valid -> illegal_ex=1, all control 0; write to x0 then read -> 0; CNT_W=2 saturate at 3.

Source files
------------

// File: rtl/id_stage_pipe.sv
// RISC-V decode stage: control/immediate decode, resettable register file with
// optional WB->ID bypass, load-use hazard detection and the registered ID/EX bundle.
module id_stage_pipe #(
  parameter  int XLEN      = 32,
  parameter  int NREG      = 32,
  parameter  int BYPASS_WB = 1,
  parameter  int HAZARD_EN = 1,
  parameter  int CNT_W     = 16,
  localparam int RW        = $clog2(NREG)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_valid_id,
  input  logic [XLEN-1:0] i_pc_id,
  input  logic [31:0]     i_instr_id,
  input  logic            i_regwrite_wb,
  input  logic [RW-1:0]   i_rd_wb,
  input  logic [XLEN-1:0] i_data_wb,
  input  logic            i_memread_ex,
  input  logic [RW-1:0]   i_rd_ex,
  input  logic            i_flush,
  output logic            o_hazard_stall,
  output logic            o_valid_ex,
  output logic [XLEN-1:0] o_pc_ex,
  output logic [XLEN-1:0] o_imm_ex,
  output logic [XLEN-1:0] o_rs1_data_ex,
  output logic [XLEN-1:0] o_rs2_data_ex,
  output logic [RW-1:0]   o_rs1_ex,
  output logic [RW-1:0]   o_rs2_ex,
  output logic [RW-1:0]   o_rd_ex,
  output logic [2:0]      o_funct3_ex,
  output logic [6:0]      o_funct7_ex,
  output logic            o_regwrite_ex,
  output logic            o_memtoreg_ex,
  output logic            o_memread_ex,
  output logic            o_memwrite_ex,
  output logic            o_alusrc_ex,
  output logic            o_branch_ex,
  output logic [1:0]      o_aluop_ex,
  output logic            o_illegal_ex,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  logic [XLEN-1:0] r_regs [NREG];

  logic [6:0]      w_opcode;
  logic [RW-1:0]   w_rs1, w_rs2, w_rd;
  logic [XLEN-1:0] w_imm, w_rs1_data, w_rs2_data;
  logic            w_regwrite, w_memtoreg, w_memread, w_memwrite, w_alusrc, w_branch;
  logic [1:0]      w_aluop;
  logic            w_illegal, w_uses_rs1, w_uses_rs2;
  logic            w_hazard, w_bubble;

  logic            r_valid_ex;
  logic [XLEN-1:0] r_pc_ex, r_imm_ex, r_rs1_data_ex, r_rs2_data_ex;
  logic [RW-1:0]   r_rs1_ex, r_rs2_ex, r_rd_ex;
  logic [2:0]      r_funct3_ex;
  logic [6:0]      r_funct7_ex;
  logic            r_regwrite_ex, r_memtoreg_ex, r_memread_ex, r_memwrite_ex, r_alusrc_ex, r_branch_ex;
  logic [1:0]      r_aluop_ex;
  logic            r_illegal_ex;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_opcode = i_instr_id[6:0];
  assign w_rd     = RW'(i_instr_id[11:7]);
  assign w_rs1    = RW'(i_instr_id[19:15]);
  assign w_rs2    = RW'(i_instr_id[24:20]);

  always_comb begin
    w_regwrite = 1'b0;
    w_memtoreg = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_alusrc   = 1'b0;
    w_branch   = 1'b0;
    w_aluop    = 2'b00;
    w_illegal  = 1'b0;
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    w_imm      = {XLEN{1'b0}};
    case (w_opcode)
      OP_R: begin
        w_regwrite = 1'b1;
        w_aluop    = 2'b10;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      OP_I: begin
        w_regwrite = 1'b1;
        w_alusrc   = 1'b1;
        w_aluop    = 2'b10;
        w_uses_rs1 = 1'b1;
        w_imm      = {{(XLEN-12){i_instr_id[31]}}, i_instr_id[31:20]};
      end
      OP_LOAD: begin
        w_regwrite = 1'b1;
        w_memtoreg = 1'b1;
        w_memread  = 1'b1;
        w_alusrc   = 1'b1;
        w_uses_rs1 = 1'b1;
        w_imm      = {{(XLEN-12){i_instr_id[31]}}, i_instr_id[31:20]};
      end
      OP_STORE: begin
        w_memwrite = 1'b1;
        w_alusrc   = 1'b1;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
        w_imm      = {{(XLEN-12){i_instr_id[31]}}, i_instr_id[31:25], i_instr_id[11:7]};
      end
      OP_BR: begin
        w_branch   = 1'b1;
        w_aluop    = 2'b01;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
        w_imm      = {{(XLEN-13){i_instr_id[31]}}, i_instr_id[31], i_instr_id[7],
                      i_instr_id[30:25], i_instr_id[11:8], 1'b0};
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Operand reads: x0 is hard zero, a same-cycle WB write can be forwarded.
  always_comb begin
    if (w_rs1 == {RW{1'b0}}) begin
      w_rs1_data = {XLEN{1'b0}};
    end else if ((BYPASS_WB != 0) && i_regwrite_wb && (i_rd_wb == w_rs1)) begin
      w_rs1_data = i_data_wb;
    end else begin
      w_rs1_data = r_regs[w_rs1];
    end
    if (w_rs2 == {RW{1'b0}}) begin
      w_rs2_data = {XLEN{1'b0}};
    end else if ((BYPASS_WB != 0) && i_regwrite_wb && (i_rd_wb == w_rs2)) begin
      w_rs2_data = i_data_wb;
    end else begin
      w_rs2_data = r_regs[w_rs2];
    end
  end

  assign w_hazard = (HAZARD_EN != 0) && i_valid_id && i_memread_ex && (i_rd_ex != {RW{1'b0}}) &&
                    ((w_uses_rs1 && (i_rd_ex == w_rs1)) || (w_uses_rs2 && (i_rd_ex == w_rs2)));
  // A flushed instruction is discarded anyway, so it must not hold the front end.
  assign o_hazard_stall = w_hazard && !i_flush;
  assign w_bubble       = i_flush || w_hazard || !i_valid_id;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= {XLEN{1'b0}};
      end
    end else if (i_regwrite_wb && (i_rd_wb != {RW{1'b0}})) begin
      r_regs[i_rd_wb] <= i_data_wb;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (o_hazard_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || w_bubble) begin
      r_valid_ex    <= 1'b0;
      r_pc_ex       <= {XLEN{1'b0}};
      r_imm_ex      <= {XLEN{1'b0}};
      r_rs1_data_ex <= {XLEN{1'b0}};
      r_rs2_data_ex <= {XLEN{1'b0}};
      r_rs1_ex      <= {RW{1'b0}};
      r_rs2_ex      <= {RW{1'b0}};
      r_rd_ex       <= {RW{1'b0}};
      r_funct3_ex   <= 3'b000;
      r_funct7_ex   <= 7'b0000000;
      r_regwrite_ex <= 1'b0;
      r_memtoreg_ex <= 1'b0;
      r_memread_ex  <= 1'b0;
      r_memwrite_ex <= 1'b0;
      r_alusrc_ex   <= 1'b0;
      r_branch_ex   <= 1'b0;
      r_aluop_ex    <= 2'b00;
      r_illegal_ex  <= 1'b0;
    end else begin
      r_valid_ex    <= 1'b1;
      r_pc_ex       <= i_pc_id;
      r_imm_ex      <= w_imm;
      r_rs1_data_ex <= w_rs1_data;
      r_rs2_data_ex <= w_rs2_data;
      r_rs1_ex      <= w_rs1;
      r_rs2_ex      <= w_rs2;
      r_rd_ex       <= w_rd;
      r_funct3_ex   <= i_instr_id[14:12];
      r_funct7_ex   <= i_instr_id[31:25];
      r_regwrite_ex <= w_regwrite;
      r_memtoreg_ex <= w_memtoreg;
      r_memread_ex  <= w_memread;
      r_memwrite_ex <= w_memwrite;
      r_alusrc_ex   <= w_alusrc;
      r_branch_ex   <= w_branch;
      r_aluop_ex    <= w_aluop;
      r_illegal_ex  <= w_illegal;
    end
  end

  assign o_valid_ex    = r_valid_ex;
  assign o_pc_ex       = r_pc_ex;
  assign o_imm_ex      = r_imm_ex;
  assign o_rs1_data_ex = r_rs1_data_ex;
  assign o_rs2_data_ex = r_rs2_data_ex;
  assign o_rs1_ex      = r_rs1_ex;
  assign o_rs2_ex      = r_rs2_ex;
  assign o_rd_ex       = r_rd_ex;
  assign o_funct3_ex   = r_funct3_ex;
  assign o_funct7_ex   = r_funct7_ex;
  assign o_regwrite_ex = r_regwrite_ex;
  assign o_memtoreg_ex = r_memtoreg_ex;
  assign o_memread_ex  = r_memread_ex;
  assign o_memwrite_ex = r_memwrite_ex;
  assign o_alusrc_ex   = r_alusrc_ex;
  assign o_branch_ex   = r_branch_ex;
  assign o_aluop_ex    = r_aluop_ex;
  assign o_illegal_ex  = r_illegal_ex;
  assign o_stall_cnt   = r_stall_cnt;

endmodule
